// File: rtl/score_sum_drain.sv
// Drains PARALLEL score_sum banks in global node order, emitting (node, score) beats whose
// score meets a latched threshold, optionally zeroing each entry right after it is read.
module score_sum_drain #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 13,
  parameter int unsigned PARALLEL      = 8,
  parameter int unsigned node_num      = 5,
  parameter int unsigned last_node_num = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          threshold,
  input  logic                           clear_en,
  output logic [ADDR_WIDTH*PARALLEL-1:0] mem_addr_score_sum,
  output logic [PARALLEL-1:0]            mem_rd_en,
  input  logic [DATA_WIDTH*PARALLEL-1:0] mem_data_in_score_sum,
  output logic [PARALLEL-1:0]            mem_score_write_sum_en,
  output logic [DATA_WIDTH*PARALLEL-1:0] mem_data_out_score_out_sum,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_node,
  output logic [DATA_WIDTH-1:0]          out_score,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_WIDTH-1:0]          count
);

  localparam int unsigned BW = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StCap  = 3'd2;
  localparam logic [2:0] StEmit = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [BW-1:0]         LastBank     = BW'(PARALLEL - 1);
  localparam logic [ADDR_WIDTH-1:0] NodeLast     = ADDR_WIDTH'(node_num - 1);
  localparam logic [ADDR_WIDTH-1:0] LastNodeLast = ADDR_WIDTH'(last_node_num - 1);

  logic [2:0]            state_q, state_d;
  logic [BW-1:0]         bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] gidx_q, gidx_d;
  logic [DATA_WIDTH-1:0] thr_q, thr_d;
  logic                  clr_q, clr_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] node_q, node_d;
  logic [DATA_WIDTH-1:0] score_q, score_d;

  logic [PARALLEL-1:0]   bank_sel;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] addr_end;
  logic                  at_bank_end;
  logic                  is_last_entry;
  logic                  adv;

  always_comb begin
    bank_sel = '0;
    rd_word  = '0;
    for (int b = 0; b < PARALLEL; b++) begin
      if (bank_q == BW'(b)) begin
        bank_sel[b] = 1'b1;
        rd_word     = mem_data_in_score_sum[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    addr_end      = (bank_q == LastBank) ? LastNodeLast : NodeLast;
    at_bank_end   = (addr_q == addr_end);
    is_last_entry = (bank_q == LastBank) && at_bank_end;
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    gidx_d  = gidx_q;
    thr_d   = thr_q;
    clr_d   = clr_q;
    count_d = count_q;
    node_d  = node_q;
    score_d = score_q;
    adv     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          thr_d   = threshold;
          clr_d   = clear_en;
          count_d = '0;
          bank_d  = '0;
          addr_d  = '0;
          gidx_d  = '0;
        end
      end
      StRead: state_d = StCap;
      StCap: begin
        score_d = rd_word;
        node_d  = gidx_q;
        if (rd_word >= thr_q) begin
          state_d = StEmit;
        end else begin
          adv = 1'b1;
        end
      end
      StEmit: begin
        if (out_ready) begin
          adv     = 1'b1;
          count_d = (&count_q) ? count_q : count_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // gidx tracks bank*node_num + addr without a multiplier
    if (adv) begin
      if (is_last_entry) begin
        state_d = StDone;
      end else begin
        state_d = StRead;
        gidx_d  = gidx_q + 1'b1;
        if (at_bank_end) begin
          addr_d = '0;
          bank_d = bank_q + 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bank_q  <= '0;
      addr_q  <= '0;
      gidx_q  <= '0;
      thr_q   <= '0;
      clr_q   <= 1'b0;
      count_q <= '0;
      node_q  <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      gidx_q  <= gidx_d;
      thr_q   <= thr_d;
      clr_q   <= clr_d;
      count_q <= count_d;
      node_q  <= node_d;
      score_q <= score_d;
    end
  end

  // Banks are read-first, so the clear write in CAP lands after the captured read.
  assign mem_addr_score_sum         = {PARALLEL{addr_q}};
  assign mem_rd_en                  = (state_q == StRead) ? bank_sel : '0;
  assign mem_score_write_sum_en     = (state_q == StCap && clr_q) ? bank_sel : '0;
  assign mem_data_out_score_out_sum = '0;
  assign out_valid                  = (state_q == StEmit);
  assign out_node                   = node_q;
  assign out_score                  = score_q;
  assign busy  = (state_q == StRead) || (state_q == StCap) || (state_q == StEmit);
  assign done  = (state_q == StDone);
  assign count = count_q;

endmodule
